// File: rtl/rtc_bus_responder.sv
// rtc_bus_responder
// Real-time clock slave on an 8-bit multiplexed address/data bus.
// The time keeping registers are packed BCD and advance once per second.
// Reads are served from shadow copies. The 0xF0 command refreshes those copies,
// so the bus master sees a coherent time snapshot.
//
// Parameters:
//   CLK_PER_SEC   clk cycles per one-second tick
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-high reset
//   ChipSelect    active-low chip select
//   Read          active-low read strobe
//   Write         active-low write strobe
//   AoD           0 = address phase, 1 = data phase
//   DATA_ADDRESS  bidirectional address/data bus, driven only during a read
//   sec_pulse     one-cycle pulse on every one-second tick
// Register map (packed BCD):
//   0x00 ctrl, 0x21 sec, 0x22 min, 0x23 hour, 0x24 day, 0x25 month, 0x26 year
// Optional feature:
//   define RTC_CHRONO_EN to add chrono registers 0x41 sec, 0x42 min, 0x43 hour.
//   The chrono runs only while ctrl bit3 is set.
module rtc_bus_responder #(
    parameter int CLK_PER_SEC = 100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ChipSelect,
    input  logic       Read,
    input  logic       Write,
    input  logic       AoD,
    inout  wire  [7:0] DATA_ADDRESS,
    output logic       sec_pulse
);
    localparam int            PW        = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_SEC - 1);
    localparam logic [7:0]    CMD_ADDR  = 8'hF0;

    typedef enum logic [2:0] {IDLE, ADDR, WDATA, RDATA, CMD} state_t;
    state_t state, state_nx;

    logic          rd_r, wr_r, wr_r_d;
    logic          wr_edge, addr_latch, data_wr, rd_cond, cmd_copy, drive;
    logic [7:0]    addr_reg, rd_data;
    logic [PW-1:0] presc;
    logic [7:0]    ctrl, sec, min, hour, day, month, year;
    logic [7:0]    sh_sec, sh_min, sh_hour, sh_day, sh_month, sh_year;
    logic          sec_wrap, min_wrap;

    // Increment a BCD byte. A low nibble of 9 or more wraps to 0 and carries.
    // This lets non-BCD values written by software still move forward.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] >= 4'd9) return {v[7:4] + 4'd1, 4'd0};
        else                return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [7:0] top);
        return (v == top) ? 8'h00 : bcd_inc(v);
    endfunction

    // Bus strobes: registered once; edges are seen on the registered copies.
    // The strobes idle high, so the reset value must not fake an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_r   <= 1'b1;
            wr_r   <= 1'b1;
            wr_r_d <= 1'b1;
        end else begin
            rd_r   <= Read;
            wr_r   <= Write;
            wr_r_d <= wr_r;
        end
    end

    assign wr_edge    = wr_r & ~wr_r_d;
    assign addr_latch = wr_edge & ~ChipSelect & ~AoD;
    assign data_wr    = wr_edge & ~ChipSelect &  AoD;
    // When Write is also asserted, the access is a write, so the bus is not driven.
    assign rd_cond    = ~ChipSelect & AoD & ~rd_r & wr_r;
    assign cmd_copy   = (state == ADDR) && (addr_reg == CMD_ADDR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            addr_reg <= 8'h00;
        end else begin
            state <= state_nx;
            if (addr_latch) addr_reg <= DATA_ADDRESS;
        end
    end

    always_comb begin
        state_nx = state;
        drive    = 1'b0;
        case (state)
            IDLE: begin
                if (addr_latch)   state_nx = ADDR;
                else if (data_wr) state_nx = WDATA;
                else if (rd_cond) state_nx = RDATA;
            end
            ADDR:       state_nx = (addr_reg == CMD_ADDR) ? CMD : IDLE;
            WDATA, CMD: state_nx = IDLE;
            RDATA: begin
                drive = 1'b1;
                if (!rd_cond) state_nx = IDLE;
            end
            default:    state_nx = IDLE;
        endcase
    end

    // One-second prescaler
    always_ff @(posedge clk) begin
        if (reset)          presc <= '0;
        else if (sec_pulse) presc <= '0;
        else                presc <= presc + 1'b1;
    end

    assign sec_pulse = (presc == PRESC_MAX);

    // Live time registers. The bus write comes after the tick, so it overrides the
    // incremented value, while the carry still reaches the next-higher register.
    assign sec_wrap = (sec == 8'h59);
    assign min_wrap = (min == 8'h59);

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl  <= 8'h00;
            sec   <= 8'h00;
            min   <= 8'h00;
            hour  <= 8'h00;
            day   <= 8'h00;
            month <= 8'h00;
            year  <= 8'h00;
        end else begin
            if (sec_pulse) begin
                sec <= bcd_step(sec, 8'h59);
                if (sec_wrap) begin
                    min <= bcd_step(min, 8'h59);
                    if (min_wrap) hour <= bcd_step(hour, 8'h23);
                end
            end
            if (data_wr) begin
                case (addr_reg)
                    8'h00:   ctrl  <= DATA_ADDRESS;
                    8'h21:   sec   <= DATA_ADDRESS;
                    8'h22:   min   <= DATA_ADDRESS;
                    8'h23:   hour  <= DATA_ADDRESS;
                    8'h24:   day   <= DATA_ADDRESS;
                    8'h25:   month <= DATA_ADDRESS;
                    8'h26:   year  <= DATA_ADDRESS;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_sec   <= 8'h00;
            sh_min   <= 8'h00;
            sh_hour  <= 8'h00;
            sh_day   <= 8'h00;
            sh_month <= 8'h00;
            sh_year  <= 8'h00;
        end else if (cmd_copy) begin
            sh_sec   <= sec;
            sh_min   <= min;
            sh_hour  <= hour;
            sh_day   <= day;
            sh_month <= month;
            sh_year  <= year;
        end
    end

`ifdef RTC_CHRONO_EN
    logic [7:0] ch_sec, ch_min, ch_hour;
    logic [7:0] sh_ch_sec, sh_ch_min, sh_ch_hour;

    always_ff @(posedge clk) begin
        if (reset) begin
            ch_sec  <= 8'h00;
            ch_min  <= 8'h00;
            ch_hour <= 8'h00;
        end else begin
            if (sec_pulse && ctrl[3]) begin
                ch_sec <= bcd_step(ch_sec, 8'h59);
                if (ch_sec == 8'h59) begin
                    ch_min <= bcd_step(ch_min, 8'h59);
                    if (ch_min == 8'h59) ch_hour <= bcd_step(ch_hour, 8'h23);
                end
            end
            if (data_wr) begin
                case (addr_reg)
                    8'h41:   ch_sec  <= DATA_ADDRESS;
                    8'h42:   ch_min  <= DATA_ADDRESS;
                    8'h43:   ch_hour <= DATA_ADDRESS;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_ch_sec  <= 8'h00;
            sh_ch_min  <= 8'h00;
            sh_ch_hour <= 8'h00;
        end else if (cmd_copy) begin
            sh_ch_sec  <= ch_sec;
            sh_ch_min  <= ch_min;
            sh_ch_hour <= ch_hour;
        end
    end
`endif

    // Read data: the shadow registers, except ctrl, which is read live.
    always_comb begin
        rd_data = 8'h00;
        case (addr_reg)
            8'h00:   rd_data = ctrl;
            8'h21:   rd_data = sh_sec;
            8'h22:   rd_data = sh_min;
            8'h23:   rd_data = sh_hour;
            8'h24:   rd_data = sh_day;
            8'h25:   rd_data = sh_month;
            8'h26:   rd_data = sh_year;
`ifdef RTC_CHRONO_EN
            8'h41:   rd_data = sh_ch_sec;
            8'h42:   rd_data = sh_ch_min;
            8'h43:   rd_data = sh_ch_hour;
`endif
            default: rd_data = 8'h00;
        endcase
    end

    assign DATA_ADDRESS = drive ? rd_data : 8'bzzzzzzzz;

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Testbench for rtc_bus_responder with CLK_PER_SEC = 10.
// A register-array model tracks live and shadow contents. It uses the time since
// reset, written as plain arithmetic, to know when each tick falls.
// One compare process checks sec_pulse every cycle. It also checks bus drive, Z or
// data whenever a bus phase is flagged. Literal expectations pin the directed cases.
module tb_rtc_bus_responder;
`ifdef RTC_CHRONO_EN
    localparam bit CHRONO = 1'b1;
`else
    localparam bit CHRONO = 1'b0;
`endif

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       cs     = 1'b1;
    logic       rd_n   = 1'b1;
    logic       wr_n   = 1'b1;
    logic       aod    = 1'b0;
    logic [7:0] drv    = 8'h00;
    logic       drv_en = 1'b0;
    logic       sec_pulse;
    wire  [7:0] bus;

    assign bus = drv_en ? drv : 8'hzz;

    rtc_bus_responder #(.CLK_PER_SEC(10)) dut (
        .clk(clk), .reset(reset), .ChipSelect(cs), .Read(rd_n), .Write(wr_n),
        .AoD(aod), .DATA_ADDRESS(bus), .sec_pulse(sec_pulse)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural model ----------------
    logic [7:0] m_live [256];
    logic [7:0] m_shad [256];
    logic [7:0] m_addr;
    int         n = 0;            // clock edges since reset released
    int         pend_edge = -1;   // edge at which the pending bus write commits
    logic       pend_aod;
    logic [7:0] pend_data;
    int         copy_edge = -1;
    int         chk_bus = 0;      // 0 none, 1 expect read data, 2 expect Z, 3 expect tb data only

    function automatic bit mapped(input logic [7:0] a);
        return (a == 8'h00) || (a >= 8'h21 && a <= 8'h26) || (CHRONO && a >= 8'h41 && a <= 8'h43);
    endfunction

    function automatic logic [7:0] read_exp(input logic [7:0] a);
        if (a == 8'h00) return m_live[0];
        if (mapped(a))  return m_shad[a];
        return 8'h00;
    endfunction

    function automatic logic [7:0] step(input logic [7:0] v, input logic [7:0] top);
        int hi, lo;
        if (v == top) return 8'h00;
        hi = int'(v) / 16;
        lo = int'(v) % 16;
        if (lo >= 9) return 8'(((hi + 1) % 16) * 16);
        return 8'(int'(v) + 1);
    endfunction

    task automatic advance(input int base);
        bit cs_, cm_;
        cs_ = (m_live[base] == 8'h59);
        cm_ = (m_live[base+1] == 8'h59);
        m_live[base] = step(m_live[base], 8'h59);
        if (cs_) begin
            m_live[base+1] = step(m_live[base+1], 8'h59);
            if (cm_) m_live[base+2] = step(m_live[base+2], 8'h23);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) begin
                m_live[i] = 8'h00;
                m_shad[i] = 8'h00;
            end
            m_addr = 8'h00; n = 0; pend_edge = -1; copy_edge = -1;
        end else begin
            logic ch_on;
            n++;
            ch_on = m_live[0][3];
            if (copy_edge == n) m_shad = m_live;
            if (n % 10 == 0) begin
                advance(8'h21);
                if (CHRONO && ch_on) advance(8'h41);
            end
            if (pend_edge == n) begin
                if (!pend_aod) begin
                    m_addr = pend_data;
                    if (pend_data == 8'hF0) copy_edge = n + 1;
                end else if (mapped(m_addr)) begin
                    m_live[m_addr] = pend_data;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    always begin
        @(posedge clk);
        #3;
        checks++;
        if (sec_pulse !== (n % 10 == 9)) begin
            errors++;
            $display("FAIL sec_pulse t=%0t got %b want %b", $time, sec_pulse, (n % 10 == 9));
        end
        if (chk_bus == 1) begin
            checks++;
            if (bus !== read_exp(m_addr)) begin
                errors++;
                $display("FAIL bus_read addr=%h got %h want %h", m_addr, bus, read_exp(m_addr));
            end
        end else if (chk_bus == 2) begin
            checks++;
            if (bus !== 8'hzz) begin
                errors++;
                $display("FAIL bus_z t=%0t got %h want zz", $time, bus);
            end
        end else if (chk_bus == 3) begin
            checks++;
            if (bus !== drv) begin
                errors++;
                $display("FAIL bus_rw_no_drive got %h want %h", bus, drv);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic lit(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic wr_cycle(input logic a_or_d, input logic [7:0] d, input bit both);
        @(negedge clk);
        cs = 1'b0; aod = a_or_d; drv = d; drv_en = 1'b1; wr_n = 1'b0;
        if (both) begin rd_n = 1'b0; chk_bus = 3; end
        @(negedge clk);
        wr_n = 1'b1; rd_n = 1'b1;
        pend_aod = a_or_d; pend_data = d; pend_edge = n + 2;
        @(negedge clk);
        @(negedge clk);
        cs = 1'b1; drv_en = 1'b0; aod = 1'b0; chk_bus = 0;
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
        wr_cycle(1'b0, a, 1'b0);
        wr_cycle(1'b1, d, 1'b0);
    endtask

    task automatic cmd();
        wr_cycle(1'b0, 8'hF0, 1'b0);
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] v);
        wr_cycle(1'b0, a, 1'b0);
        @(negedge clk); cs = 1'b0; aod = 1'b1; rd_n = 1'b0;
        @(negedge clk); chk_bus = 1;
        @(negedge clk); v = bus;
        @(negedge clk); rd_n = 1'b1; chk_bus = 0;
        @(negedge clk); chk_bus = 2;
        @(negedge clk); chk_bus = 0; cs = 1'b1; aod = 1'b0;
    endtask

    // Advance to the first negedge (strictly later) where edges-since-reset % 10 == r.
    task automatic sync(input int r);
        @(negedge clk);
        while (n % 10 != r) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [7:0] rnd_bcd();
        return {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
    endfunction

    logic [7:0] v, a, d;

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        rd(8'h00, v); lit("reset_ctrl", v, 8'h00);
        for (int i = 0; i < 6; i++) begin
            rd(8'(8'h21 + i), v); lit("reset_time", v, 8'h00);
        end

        // Write/latch/read of seconds
        wr_cycle(1'b0, 8'h21, 1'b0);
        sync(0);
        wr_cycle(1'b1, 8'h45, 1'b0);
        cmd();
        rd(8'h21, v); lit("sec_rw_45", v, 8'h45);

        // Full rollover 23:59:59 -> 00:00:00, day stays
        wr_reg(8'h24, 8'h31);
        wr_reg(8'h21, 8'h00);
        wr_reg(8'h23, 8'h23);
        wr_reg(8'h22, 8'h59);
        wr_reg(8'h21, 8'h59);
        sync(0);
        cmd();
        rd(8'h21, v); lit("roll_sec", v, 8'h00);
        rd(8'h22, v); lit("roll_min", v, 8'h00);
        rd(8'h23, v); lit("roll_hour", v, 8'h00);
        rd(8'h24, v); lit("day_storage", v, 8'h31);

        // Bus write on the tick edge wins
        wr_cycle(1'b0, 8'h21, 1'b0);
        sync(6);
        wr_cycle(1'b1, 8'h30, 1'b0);
        cmd();
        rd(8'h21, v); lit("write_beats_tick", v, 8'h30);

        // Non-BCD value advances with nibble carry
        wr_reg(8'h21, 8'h5A);
        sync(0);
        cmd();
        rd(8'h21, v); lit("non_bcd_step", v, 8'h60);

        // Unmapped address
        wr_reg(8'h7F, 8'hAB);
        rd(8'h7F, v); lit("unmapped_read", v, 8'h00);

        // Randomised traffic against the model
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 3))
                0:       a = 8'h00;
                1:       a = 8'(8'h21 + $urandom_range(0, 5));
                2:       a = 8'(8'h41 + $urandom_range(0, 2));
                default: a = 8'($urandom_range(0, 255));
            endcase
            d = ($urandom_range(0, 1) == 1) ? rnd_bcd() : 8'($urandom_range(0, 255));
            case ($urandom_range(0, 2))
                0: wr_reg(a, d);
                1: begin
                    wr_cycle(1'b0, a, 1'b0);
                    wr_cycle(1'b1, d, 1'b1);
                end
                default: begin
                    cmd();
                    rd(a, v);
                end
            endcase
        end

        // Reset during an active read
        wr_cycle(1'b0, 8'h21, 1'b0);
        @(negedge clk); cs = 1'b0; aod = 1'b1; rd_n = 1'b0;
        @(negedge clk); chk_bus = 1;
        @(negedge clk);
        @(negedge clk); reset = 1'b1; chk_bus = 2;
        @(negedge clk); reset = 1'b0; rd_n = 1'b1; cs = 1'b1; aod = 1'b0;
        @(negedge clk); chk_bus = 0;
        rd(8'h00, v); lit("post_reset_ctrl", v, 8'h00);
        for (int i = 0; i < 6; i++) begin
            rd(8'(8'h21 + i), v); lit("post_reset_time", v, 8'h00);
        end
        if (CHRONO) begin
            for (int i = 0; i < 3; i++) begin
                rd(8'(8'h41 + i), v); lit("post_reset_chrono", v, 8'h00);
            end
        end

        // Chrono: halted with bit3=0, counts 3 ticks with bit3=1
        sync(0);
        cmd();
        rd(8'h41, v); lit("chrono_halted", v, 8'h00);
        wr_reg(8'h00, 8'h08);
        sync(0); sync(0); sync(0);
        cmd();
        rd(8'h41, v); lit("chrono_3_ticks", v, CHRONO ? 8'h03 : 8'h00);
        rd(8'h00, v); lit("ctrl_storage", v, 8'h08);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
